cache_controller: RTL and testbench

Read-path controller for the direct-mapped cache. It accepts CPU word-read requests and checks its internal tag/valid store. On a hit it returns the word from the 1024 x 128-bit cache data memory. On a miss it fetches the 4-word line from main memory, writes it into the data memory, updates the tag, and returns the requested word. It drives the data memory's wrEn/address/inData and consumes its asynchronous outData.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_tag_memory.sv | 36 +++
 rtl/cache_controller.sv | 111 +++++++++++
 tb/tb_cache_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, sizes and address-field helpers for the direct-mapped read cache.
// No timing of its own; backpressure is not applicable.
package cache_pkg;

  localparam int ADDR_W         = 15;
  localparam int INDEX_W        = 10;
  localparam int TAG_W          = 3;
  localparam int OFFSET_W       = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = 32 * WORDS_PER_LINE;
  localparam int CNT_W          = 16;
  localparam int LINES          = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FETCH,
    REFILL
  } state_t;

  function automatic logic [TAG_W-1:0] getTag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] getIndex(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] getOffset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  // Word k of a line lives in bits [32k+31:32k].
  function automatic logic [31:0] getWord(input logic [LINE_W-1:0] line,
                                          input logic [OFFSET_W-1:0] offset);
    return line[{offset, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/cache_tag_memory.sv
// Tag/valid store: async read, write lands on the clock edge; valid bits cleared by reset.
// Single-cycle write, zero-latency read; always accepts, no backpressure.
module cache_tag_memory
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag_in,
  output logic [TAG_W-1:0]   tag_out,
  output logic               valid_out
);

  logic [LINES-1:0] validBits;
  logic [TAG_W-1:0] tags [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validBits <= '0;
    end else if (wr_en) begin
      validBits[index] <= 1'b1;
    end
  end

  // Tag contents are meaningless until the matching valid bit is set, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[index] <= tag_in;
    end
  end

  assign tag_out   = tags[index];
  assign valid_out = validBits[index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped read cache controller: hit returns 2 cycles after request, miss 3 cycles plus fetch time.
// Requests are only taken in IDLE (no queueing); main-memory fetch waits on mem_ack with arbitrary stalls.
module cache_controller
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ready,
  output logic [31:0]        cpu_data,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_data,
  output logic               dm_wr_en,
  output logic [INDEX_W-1:0] dm_address,
  output logic [LINE_W-1:0]  dm_in_data,
  input  logic [LINE_W-1:0]  dm_out_data,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  state_t              state;
  logic [ADDR_W-1:0]   addrQ;
  logic [OFFSET_W-1:0] wordCnt;
  logic [LINE_W-1:0]   lineBuf;
  logic [TAG_W-1:0]    storedTag;
  logic                storedValid;
  logic                tagWrEn;
  logic                hit;

  assign tagWrEn    = (state == REFILL);
  assign hit        = storedValid && (storedTag == getTag(addrQ));
  assign dm_in_data = lineBuf;

  cache_tag_memory tagStore (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (tagWrEn),
    .index     (getIndex(addrQ)),
    .tag_in    (getTag(addrQ)),
    .tag_out   (storedTag),
    .valid_out (storedValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addrQ      <= '0;
      wordCnt    <= '0;
      lineBuf    <= '0;
      cpu_ready  <= 1'b0;
      cpu_data   <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      dm_wr_en   <= 1'b0;
      dm_address <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addrQ      <= cpu_addr;
            // Index is presented one cycle early so the async data read settles during LOOKUP.
            dm_address <= getIndex(cpu_addr);
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data  <= getWord(dm_out_data, getOffset(addrQ));
            cpu_ready <= 1'b1;
            hit_count <= hit_count + CNT_W'(1);
            state     <= IDLE;
          end else begin
            miss_count <= miss_count + CNT_W'(1);
            wordCnt    <= '0;
            mem_rd     <= 1'b1;
            mem_addr   <= {getTag(addrQ), getIndex(addrQ), 2'b00};
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            lineBuf[{wordCnt, 5'd0} +: 32] <= mem_data;
            wordCnt <= wordCnt + 2'd1;
            if (wordCnt == 2'(WORDS_PER_LINE - 1)) begin
              mem_rd   <= 1'b0;
              dm_wr_en <= 1'b1;
              state    <= REFILL;
            end else begin
              mem_addr <= {getTag(addrQ), getIndex(addrQ), wordCnt + 2'd1};
            end
          end
        end
        REFILL: begin
          // Line write, tag update and CPU reply all complete on this one edge.
          dm_wr_en  <= 1'b0;
          cpu_data  <= getWord(lineBuf, getOffset(addrQ));
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller with main-memory and data-memory models.
module tb_cache_controller;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_req;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_ready;
  logic [31:0]        cpu_data;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [31:0]        mem_data;
  logic               dm_wr_en;
  logic [INDEX_W-1:0] dm_address;
  logic [LINE_W-1:0]  dm_in_data;
  logic [LINE_W-1:0]  dm_out_data;
  logic [CNT_W-1:0]   hit_count;
  logic [CNT_W-1:0]   miss_count;

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .dm_wr_en(dm_wr_en), .dm_address(dm_address),
    .dm_in_data(dm_in_data), .dm_out_data(dm_out_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [31:0] data;
    bit          hit;
    int          hits;
    int          misses;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [9:0]   a;
    logic [127:0] d;
  } wr_t;

  int total = 0, bad = 0;
  int cyc = 0, readyCount = 0, ackTotal = 0;
  int waitLeft = 0, waitConsumed = 0, maxWait = 0;

  logic [31:0]  mainMem [32768];
  logic [127:0] dmem [1024];
  exp_t         expQ [$];
  logic [14:0]  memLog [$];
  wr_t          wrLog [$];

  bit          mValid [1024];
  logic [2:0]  mTag [1024];
  int          mHits = 0, mMisses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: asynchronous read, synchronous write.
  always @(posedge clk) if (dm_wr_en) dmem[dm_address] <= dm_in_data;
  assign dm_out_data = dmem[dm_address];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 1024; i++) mValid[i] = 1'b0;
    mHits = 0;
    mMisses = 0;
  endfunction

  function automatic void modelPush(input logic [14:0] a, input int issueCyc);
    exp_t e;
    int idx = int'(a[11:2]);
    e.addr = a;
    e.hit  = mValid[idx] && (mTag[idx] == a[14:12]);
    if (e.hit) mHits++;
    else begin
      mMisses++;
      mValid[idx] = 1'b1;
      mTag[idx]   = a[14:12];
    end
    e.data   = mainMem[a];
    e.hits   = mHits;
    e.misses = mMisses;
    e.cyc    = issueCyc;
    expQ.push_back(e);
  endfunction

  // Main memory: acknowledges mem_rd after a random number of idle cycles.
  initial begin
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_rd && !rst) begin
        if (waitLeft > 0) begin
          waitLeft--;
          waitConsumed++;
        end else begin
          mem_ack  = 1'b1;
          mem_data = mainMem[mem_addr];
          memLog.push_back(mem_addr);
          ackTotal++;
          waitLeft = $urandom_range(0, maxWait);
        end
      end
    end
  end

  always @(negedge clk) if (dm_wr_en) wrLog.push_back('{dm_address, dm_in_data});

  // Monitor: every cpu_ready pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] base;
    if (cpu_ready) begin
      readyCount++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        e = expQ.pop_front();
        base = e.addr & 15'h7FFC;
        chk("cpu_data", cpu_data, e.data);
        chk("hit_count", hit_count, e.hits);
        chk("miss_count", miss_count, e.misses);
        if (e.hit) begin
          chk("hit_latency", cyc - e.cyc, 2);
          chk("hit_mem_reads", memLog.size(), 0);
          chk("hit_dm_writes", wrLog.size(), 0);
        end else begin
          chk("miss_latency", cyc - e.cyc, 7 + waitConsumed);
          chk("miss_mem_reads", memLog.size(), 4);
          for (int k = 0; k < 4 && k < memLog.size(); k++)
            chk("mem_addr", memLog[k], base + 15'(k));
          chk("miss_dm_writes", wrLog.size(), 1);
          if (wrLog.size() > 0) begin
            chk("dm_wr_index", wrLog[0].a, e.addr[11:2]);
            chk("dm_wr_line", wrLog[0].d,
                {mainMem[base + 15'd3], mainMem[base + 15'd2], mainMem[base + 15'd1], mainMem[base]});
          end
        end
      end
      memLog.delete();
      wrLog.delete();
    end
  end

  task automatic waitReady(input int target);
    for (int i = 0; i < 400 && readyCount < target; i++) @(posedge clk);
    chk("response_arrived", readyCount >= target, 1);
  endtask

  task automatic issue(input logic [14:0] a);
    int target;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = a;
    waitConsumed = 0;
    target = readyCount + 1;
    modelPush(a, cyc);
    @(negedge clk);
    cpu_req = 1'b0;
    waitReady(target);
  endtask

  initial begin
    logic [14:0] a;
    logic [14:0] b2b [3];
    int startAck, target;

    for (int i = 0; i < 32768; i++) mainMem[i] = $urandom;
    for (int i = 0; i < 4; i++) mainMem[16 + i] = 32'hA0 + 32'(i);
    modelReset();
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dm_wr_en", dm_wr_en, 0);
    chk("rst_dm_address", dm_address, 0);
    chk("rst_dm_in_data", dm_in_data, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    rst = 1'b0;

    // Cold miss, hit, then conflict on index 4.
    maxWait = 0;
    issue(15'h0012);
    issue(15'h0011);
    issue(15'h1012);
    issue(15'h0012);
    chk("conflict_miss_count", miss_count, 3);
    chk("conflict_hit_count", hit_count, 1);

    // Random traffic with memory wait states over a few contended lines.
    maxWait = 5;
    for (int n = 0; n < 40; n++) begin
      a = {3'($urandom_range(0, 3)), 10'($urandom_range(4, 7)), 2'($urandom_range(0, 3))};
      issue(a);
    end

    // Reset after the second ack of a fetch.
    maxWait = 0;
    waitLeft = 0;
    a = {3'd5, 10'h3FF, 2'd1};
    startAck = ackTotal;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 100 && ackTotal < startAck + 2; i++) @(posedge clk);
    chk("abort_two_acks", ackTotal - startAck, 2);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_dm_wr_en", dm_wr_en, 0);
    chk("abort_cpu_ready", cpu_ready, 0);
    chk("abort_dm_writes", wrLog.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    memLog.delete();
    wrLog.delete();
    waitLeft = 0;
    modelReset();
    issue(a);
    issue(a);

    // Back-to-back: cpu_req held high across three requests.
    b2b[0] = 15'h1012;
    b2b[1] = 15'h1013;
    b2b[2] = 15'h2012;
    target = readyCount + 3;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = b2b[0];
    waitConsumed = 0;
    modelPush(b2b[0], cyc);
    for (int r = 1; r < 3; r++) begin
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        #1;
        if (cpu_ready) break;
      end
      cpu_addr = b2b[r];
      waitConsumed = 0;
      modelPush(b2b[r], cyc);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    waitReady(target);
    repeat (10) @(negedge clk);
    chk("b2b_ready_count", readyCount, target);
    chk("b2b_queue_empty", expQ.size(), 0);
    chk("final_hit_count", hit_count, mHits);
    chk("final_miss_count", miss_count, mMisses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
